serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: adds two SIZE-bit signed operands one bit per
// clock, LSB first, and returns a sign-extended SIZE+1-bit sum with an overflow flag.
module serial_adder #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [SIZE:0]   result,
  output logic            overflow
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [SIZE-1:0] a_sh_q, a_sh_d;
  logic [SIZE-1:0] b_sh_q, b_sh_d;
  logic [SIZE-1:0] acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SIZE:0]   result_q, result_d;
  logic            overflow_q, overflow_d;

  logic            sum_bit;
  logic            carry_out;
  logic            sign_bit;
  logic [SIZE-1:0] acc_next;

  always_comb begin
    sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_out = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    acc_next  = {sum_bit, acc_q[SIZE-1:1]};
    // On the last bit the shift registers still hold the operand MSBs in bit 0.
    sign_bit  = a_sh_q[0] ^ b_sh_q[0] ^ carry_out;

    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    count_d    = count_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          acc_d   = '0;
          carry_d = 1'b0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        acc_d   = acc_next;
        carry_d = carry_out;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          result_d   = {sign_bit, acc_next};
          overflow_d = sign_bit ^ sum_bit;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: timeline/arithmetic reference model checked
// every cycle, plus directed literal cases for arithmetic, handshake and reset.
module tb_serial_adder;
  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start = 1'b0;
  logic [SIZE-1:0] a = '0;
  logic [SIZE-1:0] b = '0;
  logic            busy;
  logic            done;
  logic [SIZE:0]   result;
  logic            overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  serial_adder #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: m_cnt is cycles since the accepted start (-1 when idle).
  int            m_cnt = -1;
  int            m_sum;
  logic [SIZE:0] m_res = '0;
  logic [SIZE:0] pend_res = '0;
  logic          m_ovf = 1'b0;
  logic          pend_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = -1;
      m_res = '0;
      m_ovf = 1'b0;
    end else if (m_cnt < 0) begin
      if (start) begin
        m_sum    = $signed(a) + $signed(b);
        pend_res = m_sum[SIZE:0];
        pend_ovf = (m_sum > (2 ** (SIZE - 1)) - 1) || (m_sum < -(2 ** (SIZE - 1)));
        m_cnt    = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == SIZE) begin
        m_res = pend_res;
        m_ovf = pend_ovf;
      end else if (m_cnt == SIZE + 1) begin
        m_cnt = -1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_cnt >= 0);
    check("done", done, m_cnt == SIZE);
    check("result", result, m_res);
    check("overflow", overflow, m_ovf);
  end

  int   kedge, t1, t2;
  logic seen_done;

  task automatic run_op(input logic [SIZE-1:0] ta, input logic [SIZE-1:0] tb,
                        input logic [SIZE:0] er, input logic eo, input logic poke);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb;
    kedge = cyc + 1;
    @(negedge clk);
    start = 1'b0; a = SIZE'($urandom); b = SIZE'($urandom);
    check("busy_after_start", busy, 1);
    if (poke) begin
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; a = SIZE'($urandom); b = SIZE'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 4 * SIZE && done !== 1'b1; i++) @(negedge clk);
    check("done_seen", done, 1);
    check("latency", cyc - kedge, SIZE);
    check("lit_result", result, er);
    check("lit_overflow", overflow, eo);
    @(negedge clk);
    check("done_single", done, 0);
    check("result_hold", result, er);
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 9'h008, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 9'h080, 1'b1, 1'b1);
    run_op(8'h80, 8'hFF, 9'h17F, 1'b1, 1'b0);
    run_op(8'hFF, 8'h01, 9'h000, 1'b0, 1'b0);
    run_op(8'h80, 8'h80, 9'h100, 1'b1, 1'b0);

    // Start held high: back-to-back operations, done pulses SIZE+2 apart.
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h02;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 4 * (SIZE + 2) && t2 < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    check("done_spacing", t2 - t1, SIZE + 2);
    check("held_result", result, 9'h003);
    start = 1'b0;
    for (int i = 0; i < 3 * SIZE && busy !== 1'b0; i++) @(negedge clk);
    check("idle_after_held", busy, 0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; a = 8'h7F; b = 8'h7F;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_overflow", overflow, 0);
    seen_done = 1'b0;
    repeat (3) @(negedge clk) if (done === 1'b1) seen_done = 1'b1;
    rst_n = 1'b1;
    repeat (SIZE + 2) @(negedge clk) if (done === 1'b1) seen_done = 1'b1;
    check("no_done_after_reset", seen_done, 0);
    run_op(8'h10, 8'h20, 9'h030, 1'b0, 1'b0);

    // Random traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = SIZE'($urandom);
      b = SIZE'($urandom);
    end
    start = 1'b0;
    repeat (2 * SIZE) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
